dvi_pixel_reader: RTL and testbench

- Consumer end of the pixel FIFO that the frame buffer fills.
- Generates 640x480@60 raster timing with an 800x525 total raster.
- Pops one 3-bit pixel per active cycle and expands it to 24-bit RGB.
- Drives hsync, vsync and data-enable to the DVI transmitter.

---
 rtl/dvi_timing_pkg.sv | 30 +++
 rtl/dvi_timing_gen.sv | 58 +++++
 rtl/dvi_pixel_reader.sv | 98 +++++++++
 tb/tb_dvi_pixel_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// Shared timing constants, state encoding and color helper for the DVI pixel reader.
package dvi_timing_pkg;

   // 640x480@60 default raster, 800x525 total
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Raster counters are 10 bits wide, enough for an 800x525 raster
   localparam int CNT_W   = 10;
   localparam int COLOR_W = 3;

   typedef enum logic {
      WAIT   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // One FIFO color bit becomes a full-scale or zero 8-bit channel
   function automatic logic [7:0] expand_bit(input logic b);
      return {8{b}};
   endfunction

endpackage

// File: rtl/dvi_timing_gen.sv
// Horizontal/vertical raster counters and the combinational decodes of their current value.
module dvi_timing_gen
   import dvi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic rst_n,
   output logic active,
   output logic hsync_raw,
   output logic vsync_raw,
   output logic first_pixel,
   output logic last_pixel
);

   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;

   assign h_wrap = (h_cnt == H_LAST);

   // Free-running raster: h wraps every line, v advances on each h wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         if (v_cnt == V_LAST) v_cnt <= '0;
         else                 v_cnt <= v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   assign active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign hsync_raw   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign vsync_raw   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   assign first_pixel = (h_cnt == '0) && (v_cnt == '0);
   assign last_pixel  = h_wrap && (v_cnt == V_LAST);

endmodule

// File: rtl/dvi_pixel_reader.sv
// Pixel FIFO consumer: streaming FSM, pop strobe, color expansion, registered video outputs.
module dvi_pixel_reader
   import dvi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               fifo_empty,
   input  logic [COLOR_W-1:0] fifo_rd_data,
   output logic               fifo_rd_en,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [7:0]         red,
   output logic [7:0]         green,
   output logic [7:0]         blue,
   output logic               frame_start,
   output logic               underflow,
   input  logic               underflow_clr
);

   logic   active, hsync_raw, vsync_raw, first_pixel, last_pixel;
   state_t state, next_state;
   logic   go, streaming, pop, set_uf;

   dvi_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (active),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .first_pixel (first_pixel),
      .last_pixel  (last_pixel)
   );

   // Next state and pop decode; the WAIT->STREAM cycle itself already streams so pixel (0,0) is popped
   always_comb begin
      next_state = state;
      go         = rst_n && (state == WAIT) && first_pixel && enable && !fifo_empty;
      streaming  = (state == STREAM) || go;
      pop        = rst_n && streaming && active && !fifo_empty;
      set_uf     = rst_n && streaming && active && fifo_empty;
      if (go)
         next_state = STREAM;
      else if ((state == STREAM) && last_pixel && !enable)
         next_state = WAIT;
   end

   assign fifo_rd_en = pop;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT;
      else        state <= next_state;
   end

   // Video outputs registered one cycle after the counter value they decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         red         <= 8'h00;
         green       <= 8'h00;
         blue        <= 8'h00;
         frame_start <= 1'b0;
      end else begin
         hsync       <= hsync_raw ? SYNC_POL : ~SYNC_POL;
         vsync       <= vsync_raw ? SYNC_POL : ~SYNC_POL;
         de          <= active;
         red         <= pop ? expand_bit(fifo_rd_data[2]) : 8'h00;
         green       <= pop ? expand_bit(fifo_rd_data[1]) : 8'h00;
         blue        <= pop ? expand_bit(fifo_rd_data[0]) : 8'h00;
         frame_start <= streaming && first_pixel;
      end
   end

   // Sticky underflow flag; a new underflow outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             underflow <= 1'b0;
      else if (set_uf)        underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
   end

endmodule

// File: tb/tb_dvi_pixel_reader.sv
// Scoreboard bench for dvi_pixel_reader on a reduced 16x9 raster (8x4 active).
module tb_dvi_pixel_reader;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic        rd;
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
      logic        fs;
      logic        uf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [2:0] fifo_rd_data = 3'b000;
   logic       underflow_clr = 1'b0;
   logic       fifo_rd_en, hsync, vsync, de, frame_start, underflow;
   logic [7:0] red, green, blue;

   logic       rd_seen = 1'b0;
   logic       want_rstn = 1'b0, want_enable = 1'b0, want_clr = 1'b0, want_hold = 1'b0;
   logic [2:0] pix_q[$];
   exp_t       exp_q[$];

   int tests = 0, fails = 0;
   int pops = 0, fs_cnt = 0, hs_low = 0, vs_low = 0, de_cnt = 0;
   int mh = 0, mv = 0;
   bit mstream = 0, muf = 0;

   dvi_pixel_reader #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (1'b0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .fifo_empty    (fifo_empty),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_en    (fifo_rd_en),
      .hsync         (hsync),
      .vsync         (vsync),
      .de            (de),
      .red           (red),
      .green         (green),
      .blue          (blue),
      .frame_start   (frame_start),
      .underflow     (underflow),
      .underflow_clr (underflow_clr)
   );

   // Pixel clock
   always #5 clk = ~clk;

   // Remember whether the DUT popped on this edge
   always @(posedge clk) rd_seen <= fifo_rd_en;

   // Hand-written color table
   function automatic logic [23:0] colorOf(input logic [2:0] p);
      case (p)
         3'b000:  return 24'h000000;
         3'b001:  return 24'h0000FF;
         3'b010:  return 24'h00FF00;
         3'b011:  return 24'h00FFFF;
         3'b100:  return 24'hFF0000;
         3'b101:  return 24'hFF00FF;
         3'b110:  return 24'hFFFF00;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Predict the DUT response to the next rising edge and queue it
   task automatic pushExpected();
      exp_t e;
      bit act, first, last, go, str;
      if (!rst_n) begin
         mh = 0; mv = 0; mstream = 0; muf = 0;
         e = '{rd: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'h0, fs: 1'b0, uf: 1'b0};
      end else begin
         act   = (mh < HA) && (mv < VA);
         first = (mh == 0) && (mv == 0);
         last  = (mh == HT - 1) && (mv == VT - 1);
         go    = !mstream && first && enable && !fifo_empty;
         str   = mstream || go;
         e.rd  = str && act && !fifo_empty;
         e.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
         e.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
         e.de  = act;
         e.rgb = e.rd ? colorOf(fifo_rd_data) : 24'h0;
         e.fs  = str && first;
         if (str && act && fifo_empty) muf = 1;
         else if (underflow_clr)       muf = 0;
         e.uf  = muf;
         if (go) mstream = 1;
         else if (mstream && last && !enable) mstream = 0;
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end
      end
      exp_q.push_back(e);
   endtask

   // One cycle: retire last pop, drive inputs at the falling edge, queue the expectation
   task automatic applyStimulus();
      @(negedge clk);
      if (rd_seen) begin
         pops++;
         if (pix_q.size() > 0) void'(pix_q.pop_front());
      end
      if (frame_start) fs_cnt++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (de) de_cnt++;
      rst_n         = want_rstn;
      enable        = want_enable;
      underflow_clr = want_clr;
      fifo_empty    = want_hold || (pix_q.size() == 0);
      fifo_rd_data  = (pix_q.size() > 0) ? pix_q[0] : 3'b000;
      pushExpected();
   endtask

   task automatic runSteps(input int n);
      repeat (n) applyStimulus();
   endtask

   task automatic clearCounts();
      pops = 0; fs_cnt = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
   endtask

   // Monitor: compare every output against the queued expectation just after each edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("fifo_rd_en", 24'(rd_seen), 24'(e.rd));
         checkOutput("hsync", 24'(hsync), 24'(e.hs));
         checkOutput("vsync", 24'(vsync), 24'(e.vs));
         checkOutput("de", 24'(de), 24'(e.de));
         checkOutput("rgb", {red, green, blue}, e.rgb);
         checkOutput("frame_start", 24'(frame_start), 24'(e.fs));
         checkOutput("underflow", 24'(underflow), 24'(e.uf));
      end
   end

   initial begin
      // Power-on reset, then FIFO empty at frame start and filled at line 2
      runSteps(3);
      checkOutput("reset_hsync", 24'(hsync), 24'h1);
      checkOutput("reset_de", 24'(de), 24'h0);
      want_rstn = 1'b1; want_enable = 1'b1;
      clearCounts();
      runSteps(2 * HT);
      pix_q.push_back(3'b101);
      pix_q.push_back(3'b010);
      for (int i = 2; i < 32; i++) pix_q.push_back(3'(i % 8));
      runSteps(FRAME - 2 * HT);
      checkOutput("late_fill_pops", 24'(pops), 24'd0);
      checkOutput("late_fill_fs", 24'(fs_cnt), 24'd0);
      checkOutput("late_fill_uf", 24'(underflow), 24'd0);

      // Full streaming frame
      clearCounts();
      runSteps(2);
      checkOutput("pix0_rgb", {red, green, blue}, 24'hFF00FF);
      checkOutput("pix0_de", 24'(de), 24'h1);
      runSteps(1);
      checkOutput("pix1_rgb", {red, green, blue}, 24'h00FF00);
      runSteps(FRAME - 3);
      checkOutput("frame_pops", 24'(pops), 24'd32);
      checkOutput("frame_fs", 24'(fs_cnt), 24'd1);
      checkOutput("hsync_low_cycles", 24'(hs_low), 24'd27);
      checkOutput("vsync_low_cycles", 24'(vs_low), 24'd32);

      // Mid-line underflow, clear, and clear colliding with a new underflow
      clearCounts();
      for (int i = 0; i < 26; i++) pix_q.push_back(3'((i * 3) % 8));
      runSteps(18);
      want_hold = 1'b1; runSteps(5);
      want_hold = 1'b0; runSteps(3);
      checkOutput("uf_set", 24'(underflow), 24'h1);
      want_clr = 1'b1; runSteps(1);
      want_clr = 1'b0; runSteps(2);
      checkOutput("uf_cleared", 24'(underflow), 24'h0);
      runSteps(3);
      want_hold = 1'b1; want_clr = 1'b1; runSteps(1);
      want_hold = 1'b0; want_clr = 1'b0; runSteps(2);
      checkOutput("uf_set_wins", 24'(underflow), 24'h1);
      runSteps(FRAME - 35);
      checkOutput("uf_frame_pops", 24'(pops), 24'd26);

      // Enable dropped mid-frame: frame completes, next frame idle
      clearCounts();
      for (int i = 0; i < 40; i++) pix_q.push_back(3'(7 - (i % 8)));
      runSteps(2 * HT + 4);
      want_enable = 1'b0;
      runSteps(FRAME - (2 * HT + 4));
      checkOutput("drop_frame_pops", 24'(pops), 24'd32);
      clearCounts();
      runSteps(FRAME);
      checkOutput("idle_pops", 24'(pops), 24'd0);
      checkOutput("idle_fs", 24'(fs_cnt), 24'd0);
      checkOutput("idle_de_cycles", 24'(de_cnt), 24'd32);

      // Asynchronous reset mid-line, then re-alignment at (0,0)
      want_enable = 1'b1; want_clr = 1'b1;
      for (int i = 0; i < 24; i++) pix_q.push_back(3'b110);
      runSteps(1);
      want_clr = 1'b0;
      runSteps(HT + 3);
      #2;
      rst_n = 1'b0; want_rstn = 1'b0;
      #1;
      checkOutput("async_rd_en", 24'(fifo_rd_en), 24'h0);
      checkOutput("async_de", 24'(de), 24'h0);
      checkOutput("async_hsync", 24'(hsync), 24'h1);
      checkOutput("async_vsync", 24'(vsync), 24'h1);
      checkOutput("async_rgb", {red, green, blue}, 24'h0);
      checkOutput("async_fs", 24'(frame_start), 24'h0);
      exp_q.delete();
      pushExpected();
      runSteps(3);
      clearCounts();
      want_rstn = 1'b1;
      runSteps(FRAME);
      checkOutput("resume_pops", 24'(pops), 24'd21);
      checkOutput("resume_fs", 24'(fs_cnt), 24'd1);
      checkOutput("resume_uf", 24'(underflow), 24'h1);

      runSteps(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
